// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// instruction size and the default reset fetch address.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,  // request outstanding to instruction memory
        S_HOLD = 1'b1   // word parked in skid buffer while decode is stalled
    } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: instruction word, its address and a valid bit.
// A flush only drops the valid bit; the data fields keep their last value.
module if_id_register #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  valid_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, request FSM with a one-word skid buffer for decode
// stalls, and redirect handling; feeds the IF/ID register.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PCSource,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic                  Stall,
    output logic                  ImemReq,
    output logic [DATA_WIDTH-1:0] ImemAddr,
    input  logic                  ImemReady,
    input  logic [DATA_WIDTH-1:0] ImemData,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic                  ValidD
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(INSTR_BYTES);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(INSTR_BYTES - 1);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic                  load;
    logic                  flush;
    logic [DATA_WIDTH-1:0] load_instr;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        load       = 1'b0;
        flush      = 1'b0;
        load_instr = ImemData;

        if (PCSource) begin
            // Redirect overrides everything; any returning or parked word is dropped.
            pc_d    = BranchTarget & ALIGN_MASK;
            flush   = 1'b1;
            state_d = S_REQ;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (ImemReady) begin
                        if (Stall) begin
                            buf_d   = ImemData;
                            state_d = S_HOLD;
                        end else begin
                            load = 1'b1;
                            pc_d = pc_q + PC_STEP;
                        end
                    end
                end
                S_HOLD: begin
                    if (!Stall) begin
                        load       = 1'b1;
                        load_instr = buf_q;
                        pc_d       = pc_q + PC_STEP;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // NOTE: the skid buffer is a single register, so it is reset along with the
    // rest of the state; the FSM state alone decides whether it holds data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    // Gated by reset so no request escapes while the stage is held in reset.
    assign ImemReq  = rst && (state_q == S_REQ);
    assign ImemAddr = pc_q;

    if_id_register #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .flush_i (flush),
        .instr_i (load_instr),
        .pc_i    (pc_q),
        .instr_o (InstrD),
        .pc_o    (PCD),
        .valid_o (ValidD)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycles push expected IF/ID
// contents into a scoreboard that a monitor pops after each rising edge.
module tb_fetch_unit;

    localparam int unsigned W = 32;

    typedef struct {
        logic         v;
        logic [W-1:0] pcd;
        logic [W-1:0] instr;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         PCSource;
    logic [W-1:0] BranchTarget;
    logic         Stall;
    logic         ImemReq;
    logic [W-1:0] ImemAddr;
    logic         ImemReady;
    logic [W-1:0] ImemData;
    logic [W-1:0] InstrD;
    logic [W-1:0] PCD;
    logic         ValidD;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t mon_e;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign ImemData = mem_word(ImemAddr);

    fetch_unit #(
        .DATA_WIDTH(W),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PCSource     (PCSource),
        .BranchTarget (BranchTarget),
        .Stall        (Stall),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemReady    (ImemReady),
        .ImemData     (ImemData),
        .InstrD       (InstrD),
        .PCD          (PCD),
        .ValidD       (ValidD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge: drive inputs, check the request side,
    // queue the IF/ID contents expected after the next rising edge.
    task automatic cyc(input logic rdy, input logic stl, input logic ps, input logic [W-1:0] tgt,
                       input logic e_req, input logic [W-1:0] e_addr,
                       input logic e_v, input logic [W-1:0] e_pcd);
        exp_t e;
        ImemReady    = rdy;
        Stall        = stl;
        PCSource     = ps;
        BranchTarget = tgt;
        #1;
        check("imem_req", W'(ImemReq), W'(e_req));
        check("imem_addr", ImemAddr, e_addr);
        e.v     = e_v;
        e.pcd   = e_pcd;
        e.instr = mem_word(e_pcd);
        sb.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("valid_d", W'(ValidD), W'(mon_e.v));
            check("pcd", PCD, mon_e.pcd);
            check("instr_d", InstrD, mon_e.instr);
        end
    end

    initial begin
        rst          = 1'b0;
        PCSource     = 1'b0;
        BranchTarget = '0;
        Stall        = 1'b0;
        ImemReady    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", W'(ImemReq), '0);
        check("rst_addr", ImemAddr, 32'h0);
        check("rst_valid", W'(ValidD), '0);
        check("rst_pcd", PCD, 32'h0);
        check("rst_instr", InstrD, 32'h0);

        rst = 1'b1;
        // Zero-wait streaming: PCD trails ImemAddr by one cycle.
        cyc(1, 0, 0, 0, 1, 32'h0, 1, 32'h0);
        cyc(1, 0, 0, 0, 1, 32'h4, 1, 32'h4);
        // Multi-cycle memory at PC=8: address and IF/ID hold.
        cyc(0, 0, 0, 0, 1, 32'h8, 1, 32'h4);
        cyc(0, 0, 0, 0, 1, 32'h8, 1, 32'h4);
        cyc(0, 0, 0, 0, 1, 32'h8, 1, 32'h4);
        cyc(1, 0, 0, 0, 1, 32'h8, 1, 32'h8);
        // Stall as word@12 arrives: parked, no request, then delivered once.
        cyc(1, 1, 0, 0, 1, 32'hC, 1, 32'h8);
        cyc(1, 1, 0, 0, 0, 32'hC, 1, 32'h8);
        cyc(1, 0, 0, 0, 0, 32'hC, 1, 32'hC);
        cyc(1, 0, 0, 0, 1, 32'h10, 1, 32'h10);
        // Redirect while parked: buffered word@20 is discarded, target aligned.
        cyc(1, 1, 0, 0, 1, 32'h14, 1, 32'h10);
        cyc(1, 1, 1, 32'h0000_0103, 0, 32'h14, 0, 32'h10);
        cyc(1, 0, 0, 0, 1, 32'h100, 1, 32'h100);
        // Redirect with a returning word: word dropped, PC wraps past top.
        cyc(1, 0, 1, 32'hFFFF_FFFE, 1, 32'h104, 0, 32'h100);
        cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 1, 32'h0, 1, 32'h0);
        // Stall with no ready keeps ValidD.
        cyc(0, 1, 0, 0, 1, 32'h4, 1, 32'h0);
        cyc(1, 0, 0, 0, 1, 32'h4, 1, 32'h4);
        cyc(1, 0, 0, 0, 1, 32'h8, 1, 32'h8);
        cyc(1, 0, 0, 0, 1, 32'hC, 1, 32'hC);
        cyc(1, 0, 0, 0, 1, 32'h10, 1, 32'h10);
        cyc(0, 0, 0, 0, 1, 32'h14, 1, 32'h10);

        // Reset mid-wait at PC=20, asserted away from any clock edge.
        ImemReady = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_req", W'(ImemReq), '0);
        check("midrst_addr", ImemAddr, 32'h0);
        check("midrst_valid", W'(ValidD), '0);
        check("midrst_pcd", PCD, 32'h0);
        check("midrst_instr", InstrD, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc(1, 0, 0, 0, 1, 32'h0, 1, 32'h0);
        cyc(1, 0, 0, 0, 1, 32'h4, 1, 32'h4);

        check("sb_drained", W'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of PC, addresses and instructions.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 PCSource  input  1  redirect request from jump_unit; 1 = take BranchTarget.
REQ-006 BranchTarget  input  DATA_WIDTH  redirect address, valid while PCSource=1.
REQ-007 Stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-008 ImemReq  output  1  instruction memory request.
REQ-009 ImemAddr  output  DATA_WIDTH  fetch address; equals PC.
REQ-010 ImemReady  input  1  memory returns ImemData for ImemAddr this cycle.
REQ-011 ImemData  input  DATA_WIDTH  instruction word.
REQ-012 InstrD, PCD  output  DATA_WIDTH each  IF/ID register: instruction and its address.
REQ-013 ValidD  output  1  InstrD/PCD hold a live instruction.

Function
REQ-014 States: S_REQ (request outstanding), S_HOLD (word buffered, decode stalled).
REQ-015 S_REQ: ImemReq=1, ImemAddr=PC; state and PC unchanged while ImemReady=0 (multi-cycle memory allowed).
REQ-016 S_REQ, ImemReady=1, Stall=0: InstrD<=ImemData, PCD<=PC, ValidD<=1, PC<=PC+4, stay S_REQ; one instruction per cycle with zero-wait memory.
REQ-017 S_REQ, ImemReady=1, Stall=1: ImemData captured in skid buffer, PC unchanged, go S_HOLD; IF/ID outputs hold.
REQ-018 S_HOLD: ImemReq=0; when Stall=0, IF/ID loads buffer word with PCD<=PC, ValidD<=1, PC<=PC+4, go S_REQ.
REQ-019 Stall=1 with no ImemReady: IF/ID outputs hold, including ValidD.
REQ-020 PCSource=1 has highest priority in any state, regardless of Stall or ImemReady: PC<=BranchTarget with bits [1:0] forced to 0, ValidD<=0 (flush), buffer discarded, state<=S_REQ; the returning word, if any, is dropped.
REQ-021 Redirect may abandon an outstanding request; the memory follows the new ImemAddr from the next cycle.
REQ-022 PC+4 wraps modulo 2^DATA_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000) with no error.
REQ-023 InstrD/PCD are not cleared by a flush; only ValidD qualifies them.

Reset
REQ-024 rst=0 asynchronously forces PC=RESET_PC, state=S_REQ, ValidD=0, InstrD=0, PCD=0, buffer empty.
REQ-025 During reset ImemReq=0; the first request is issued in the first cycle after rst deasserts, with ImemAddr=RESET_PC.
REQ-026 Reset asserted mid-wait or in S_HOLD discards the outstanding or buffered word.

Structure
REQ-027 Package fetch_pkg holds the state enum, INSTR_BYTES=4 and the RESET_PC default.
REQ-028 IF/ID register (InstrD, PCD, ValidD with load/flush enables) is sub-module if_id_register; the PC, FSM and skid buffer stay in fetch_unit.

Verification
REQ-029 Reset release, ImemReady tied 1, Stall=0 -> ImemAddr 0,4,8,...; PCD lags ImemAddr by one cycle; ValidD=1 from cycle 2.
REQ-030 ImemReady low for 3 cycles at PC=8 -> ImemAddr stays 8 and ImemReq=1 for those cycles; IF/ID holds; then InstrD=word@8.
REQ-031 Stall=1 for 2 cycles while word@12 arrives -> S_HOLD, ImemReq=0; Stall drops -> InstrD=word@12, PCD=12, next ImemAddr=16, no word lost or duplicated.
REQ-032 PCSource=1, BranchTarget=32'h0000_0103, during Stall in S_HOLD -> next cycle ImemAddr=32'h100, ValidD=0, buffered word never appears on InstrD.
REQ-033 PC=32'hFFFF_FFFC, ImemReady=1 -> next ImemAddr=32'h0000_0000.
REQ-034 rst asserted mid-wait at PC=20 -> outputs at reset values immediately; after release ImemAddr=RESET_PC.
